// File: rtl/sort_seq_pkg.sv
// rtl/sort_seq_pkg.sv - state encoding and frame-depth helper shared by the sort stream sequencer
package sort_seq_pkg;

  typedef enum logic [2:0] {
    ST_LOAD       = 3'd0,
    ST_START      = 3'd1,
    ST_WAIT       = 3'd2,
    ST_RD_ISSUE   = 3'd3,
    ST_RD_CAPTURE = 3'd4,
    ST_OUT_HOLD   = 3'd5
  } state_e;

  function automatic int unsigned depth_of(input int unsigned l);
    return 32'd1 << l;
  endfunction

endpackage

// File: rtl/sort_stream_sequencer.sv
// rtl/sort_stream_sequencer.sv - loads a frame into the sorter core, runs it, and streams the sorted words out
module sort_stream_sequencer
  import sort_seq_pkg::*;
#(
  parameter int N       = 8,
  parameter int L       = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         frame_done,
  output logic         err,
  output logic         srt_s,
  input  logic         srt_done,
  output logic         srt_wrinit,
  output logic         srt_rd,
  output logic [L-1:0] srt_radd,
  output logic [N-1:0] srt_datain,
  input  logic [N-1:0] srt_dataout
);

  localparam int            DEPTH    = int'(depth_of(L));
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [L-1:0]  LAST_IDX = L'(DEPTH - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [L-1:0]  wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d, frame_done_q, frame_done_d;
  logic          err_q, err_d, s_q, s_d, wrinit_q, wrinit_d, rd_q, rd_d;
  logic [N-1:0]  out_data_q, out_data_d, datain_q, datain_d;
  logic [L-1:0]  radd_q, radd_d;
  logic          in_hs;

  assign in_hs = (state_q == ST_LOAD) && in_ready_q && in_valid;

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    rcnt_d       = rcnt_q;
    tcnt_d       = tcnt_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;
    err_d        = err_q;
    s_d          = s_q;
    rd_d         = rd_q;
    radd_d       = radd_q;
    datain_d     = datain_q;
    wrinit_d     = 1'b0;
    frame_done_d = 1'b0;
    // in_ready lags entry into LOAD by one cycle and drops right after the final beat
    in_ready_d   = (state_q == ST_LOAD) && !(in_hs && (wcnt_q == LAST_IDX));

    case (state_q)
      ST_LOAD: begin
        if (in_hs) begin
          wrinit_d = 1'b1;
          radd_d   = wcnt_q;
          datain_d = in_data;
          wcnt_d   = wcnt_q + 1'b1;
          if (wcnt_q == LAST_IDX) state_d = ST_START;
        end
      end
      ST_START: begin
        s_d     = 1'b1;
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (srt_done) begin
          s_d     = 1'b0;
          rd_d    = 1'b1;
          radd_d  = rcnt_q;
          state_d = ST_RD_ISSUE;
        end else if (tcnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          s_d     = 1'b0;
          state_d = ST_LOAD;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_CAPTURE;
      ST_RD_CAPTURE: begin
        out_data_d  = srt_dataout;
        out_valid_d = 1'b1;
        out_last_d  = (rcnt_q == LAST_IDX);
        state_d     = ST_OUT_HOLD;
      end
      ST_OUT_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (rcnt_q != LAST_IDX) begin
            rcnt_d  = rcnt_q + 1'b1;
            radd_d  = rcnt_q + 1'b1;
            state_d = ST_RD_ISSUE;
          end else begin
            rcnt_d       = '0;
            rd_d         = 1'b0;
            frame_done_d = 1'b1;
            state_d      = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      tcnt_q       <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      s_q          <= 1'b0;
      wrinit_q     <= 1'b0;
      rd_q         <= 1'b0;
      radd_q       <= '0;
      datain_q     <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      tcnt_q       <= tcnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      s_q          <= s_d;
      wrinit_q     <= wrinit_d;
      rd_q         <= rd_d;
      radd_q       <= radd_d;
      datain_q     <= datain_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign srt_s      = s_q;
  assign srt_wrinit = wrinit_q;
  assign srt_rd     = rd_q;
  assign srt_radd   = radd_q;
  assign srt_datain = datain_q;

endmodule
